// File: rtl/fairy_fetch_stage.sv
// Fetch front end: owns the PC, issues single-outstanding SRAM fetches and
// buffers one {pc, inst} toward decode; consumes exception/eret/branch redirects.
//
//   state  | meaning
//   IDLE   | no request outstanding, waiting for the output buffer to free
//   REQ    | inst_req_o high at fetch_pc, held until gnt
//   WAIT   | request issued, waiting for rvalid (dropped if drop_q is set)
module fairy_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        exception_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_gnt_i,
   input  logic        inst_rvalid_i,
   input  logic [31:0] inst_rdata_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
   logic [31:0] br_target_q, br_target_d, last_pc_q, last_pc_d;
   logic [31:0] pc_q, pc_d, inst_q, inst_d;
   logic        valid_q, valid_d, drop_q, drop_d, br_pending_q, br_pending_d;

   logic        issue, handoff, flush, br, br_late, kill_wait;
   logic [31:0] flush_pc, br_tgt, ds_pc, ds_next;

   assign issue     = (state_q == S_REQ) & inst_gnt_i;
   assign handoff   = valid_q & ready_i;
   assign flush     = exception_i | eret_i;
   assign flush_pc  = exception_i ? EXC_VECTOR : (epc_i & ~32'd3);
   assign br        = br_taken_i & ~flush;
   assign br_tgt    = br_target_i & ~32'd3;
   assign ds_pc     = last_pc_q + 32'd4;
   assign ds_next   = ds_pc + 32'd4;
   // Delay slot already requested or buffered: redirect now, kill anything younger.
   assign br_late   = br & (fetch_pc_q != ds_pc);
   assign kill_wait = flush | (br_late & (req_pc_q == ds_next));

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      br_target_d  = br_target_q;
      last_pc_d    = last_pc_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      valid_d      = valid_q;
      drop_d       = drop_q;
      br_pending_d = br_pending_q;

      if (handoff) begin
         valid_d   = 1'b0;
         last_pc_d = pc_q;
      end
      if (flush || (br_late && valid_q && (pc_q == ds_next)))
         valid_d = 1'b0;

      case (state_q)
         S_REQ: begin
            if (issue) begin
               state_d    = S_WAIT;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (br_pending_q) begin
                  fetch_pc_d   = br_target_q;
                  br_pending_d = 1'b0;
               end
               if (flush || (br_late && (fetch_pc_q == ds_next)))
                  drop_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (inst_rvalid_i) begin
               state_d = S_IDLE;
               drop_d  = 1'b0;
               if (!drop_q && !kill_wait) begin
                  valid_d = 1'b1;
                  pc_d    = req_pc_q;
                  inst_d  = inst_rdata_i;
               end
            end else if (kill_wait) begin
               drop_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (flush) begin
         fetch_pc_d   = flush_pc;
         br_pending_d = 1'b0;
      end else if (br) begin
         if (br_late || issue) begin
            fetch_pc_d = br_tgt;
         end else begin
            br_pending_d = 1'b1;
            br_target_d  = br_tgt;
         end
      end

      // Only fetch when the returning word is guaranteed a free buffer slot.
      if ((state_d == S_IDLE) && !valid_d)
         state_d = S_REQ;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= 32'd0;
         br_target_q  <= 32'd0;
         last_pc_q    <= 32'd0;
         pc_q         <= 32'd0;
         inst_q       <= 32'd0;
         valid_q      <= 1'b0;
         drop_q       <= 1'b0;
         br_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         br_target_q  <= br_target_d;
         last_pc_q    <= last_pc_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         valid_q      <= valid_d;
         drop_q       <= drop_d;
         br_pending_q <= br_pending_d;
      end
   end

   assign inst_req_o  = (state_q == S_REQ);
   assign inst_addr_o = fetch_pc_q;
   assign valid_o     = valid_q;
   assign pc_o        = pc_q;
   assign inst_o      = inst_q;
endmodule
